// File: rtl/if_slice.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding-request handshake to imem, feeds ID.
// Latency: one cycle from imem response to instr; ID stall holds outputs, a response landing under stall parks in a 1-entry skid.
module if_slice #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter logic [15:0] BUBBLE_INSTR = 16'hF000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] target,
   input  logic        halt,
   output logic        imem_re,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_rdy,
   output logic [15:0] instr,
   output logic [15:0] PC_inc,
   output logic        instr_valid,
   output logic        halted
);

   typedef enum logic [2:0] {S_RUN, S_WAIT, S_SKID, S_DRAIN, S_HALTED} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_inc_q, pc_inc_d;
   logic        valid_q, valid_d;
   logic [15:0] skid_q, skid_d;
   logic [15:0] drain_addr_q, drain_addr_d;
   logic        started_q;
   logic        req;
   logic        rsp;
   logic [15:0] req_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         pc_q         <= RESET_PC;
         instr_q      <= BUBBLE_INSTR;
         pc_inc_q     <= 16'h0000;
         valid_q      <= 1'b0;
         skid_q       <= BUBBLE_INSTR;
         drain_addr_q <= 16'h0000;
         started_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc_inc_q     <= pc_inc_d;
         valid_q      <= valid_d;
         skid_q       <= skid_d;
         drain_addr_q <= drain_addr_d;
         started_q    <= 1'b1;
      end
   end

   // Request side: RUN only issues once the first post-reset edge has passed.
   always_comb begin
      req      = 1'b0;
      req_addr = pc_q;
      case (state_q)
         S_RUN:   req = started_q;
         S_WAIT:  req = 1'b1;
         S_DRAIN: begin
            req      = 1'b1;
            req_addr = drain_addr_q;
         end
         default: req = 1'b0;
      endcase
      rsp = req & imem_rdy;
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc_inc_d     = pc_inc_q;
      valid_d      = valid_q;
      skid_d       = skid_q;
      drain_addr_d = drain_addr_q;

      if (halt) begin
         state_d = S_HALTED;
         instr_d = BUBBLE_INSTR;
         valid_d = 1'b0;
      end else if (state_q == S_HALTED) begin
         state_d = S_HALTED;
      end else if (redirect) begin
         // Old request (if still pending) must complete at its own address before the target is fetched.
         pc_d         = target;
         instr_d      = BUBBLE_INSTR;
         valid_d      = 1'b0;
         skid_d       = BUBBLE_INSTR;
         drain_addr_d = req_addr;
         state_d      = (req && !imem_rdy) ? S_DRAIN : S_RUN;
      end else begin
         case (state_q)
            S_RUN, S_WAIT: begin
               if (req) begin
                  if (rsp && !stall) begin
                     instr_d  = imem_rdata;
                     pc_inc_d = pc_q + 16'd1;
                     valid_d  = 1'b1;
                     pc_d     = pc_q + 16'd1;
                     state_d  = S_RUN;
                  end else if (rsp) begin
                     skid_d  = imem_rdata;
                     pc_d    = pc_q + 16'd1;
                     state_d = S_SKID;
                  end else begin
                     if (!stall) begin
                        instr_d = BUBBLE_INSTR;
                        valid_d = 1'b0;
                     end
                     state_d = S_WAIT;
                  end
               end
            end
            S_SKID: begin
               // pc already advanced past the parked word, so it equals that word's PC+1.
               if (!stall) begin
                  instr_d  = skid_q;
                  pc_inc_d = pc_q;
                  valid_d  = 1'b1;
                  state_d  = S_RUN;
               end
            end
            S_DRAIN: begin
               if (rsp) state_d = S_RUN;
            end
            default: state_d = S_HALTED;
         endcase
      end
   end

   assign imem_re     = req;
   assign imem_addr   = req_addr;
   assign instr       = instr_q;
   assign PC_inc      = pc_inc_q;
   assign instr_valid = valid_q;
   assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_if_slice.sv
// Directed bench for if_slice: word-per-cycle fetch, late memory, stall skid, redirect drain, wrap, halt and reset.
module tb_if_slice;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect, halt, imem_rdy;
   logic [15:0] target;
   logic        imem_re;
   logic [15:0] imem_addr, imem_rdata;
   logic [15:0] instr, PC_inc;
   logic        instr_valid, halted;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // mem[i] = 16'h1000 + i
   assign imem_rdata = 16'h1000 + imem_addr;

   if_slice dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .target(target),
      .halt(halt), .imem_re(imem_re), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_rdy(imem_rdy), .instr(instr), .PC_inc(PC_inc), .instr_valid(instr_valid),
      .halted(halted)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] e_instr, input logic [15:0] e_inc,
                          input logic e_vld);
      chk({tag, "_instr"}, instr, e_instr);
      chk({tag, "_pcinc"}, PC_inc, e_inc);
      chk({tag, "_valid"}, {15'd0, instr_valid}, {15'd0, e_vld});
   endtask

   task automatic chk_req(input string tag, input logic e_re, input logic [15:0] e_addr);
      chk({tag, "_re"}, {15'd0, imem_re}, {15'd0, e_re});
      if (e_re) chk({tag, "_addr"}, imem_addr, e_addr);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; imem_rdy = 1'b0; target = 16'h0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk_out("reset", 16'hF000, 16'h0000, 1'b0);
      chk_req("reset", 1'b0, 16'h0);
      chk("reset_halted", {15'd0, halted}, 16'h0);
      // Release with a stray rdy present: no request yet, so it must be ignored.
      rst_n = 1'b1; imem_rdy = 1'b1;

      // 1: back-to-back fetch
      @(negedge clk);
      chk_req("t1_first", 1'b1, 16'h0000);
      chk("t1_first_valid", {15'd0, instr_valid}, 16'h0);
      @(negedge clk); chk_out("t1_w0", 16'h1000, 16'h0001, 1'b1);
      @(negedge clk); chk_out("t1_w1", 16'h1001, 16'h0002, 1'b1);
      @(negedge clk); chk_out("t1_w2", 16'h1002, 16'h0003, 1'b1);
      chk_req("t1_next", 1'b1, 16'h0003);

      // 2: response 3 cycles late on addr 3
      imem_rdy = 1'b0;
      @(negedge clk); chk_out("t2_b0", 16'hF000, 16'h0003, 1'b0); chk_req("t2_b0", 1'b1, 16'h0003);
      @(negedge clk); chk_out("t2_b1", 16'hF000, 16'h0003, 1'b0); chk_req("t2_b1", 1'b1, 16'h0003);
      @(negedge clk); chk_out("t2_b2", 16'hF000, 16'h0003, 1'b0); chk_req("t2_b2", 1'b1, 16'h0003);
      imem_rdy = 1'b1;
      @(negedge clk); chk_out("t2_w3", 16'h1003, 16'h0004, 1'b1); chk_req("t2_n", 1'b1, 16'h0004);

      // 3: stall for 2 cycles as mem[5] returns
      @(negedge clk); chk_out("t3_w4", 16'h1004, 16'h0005, 1'b1); chk_req("t3_r5", 1'b1, 16'h0005);
      stall = 1'b1;
      @(negedge clk); chk_out("t3_h0", 16'h1004, 16'h0005, 1'b1); chk_req("t3_skid0", 1'b0, 16'h0);
      @(negedge clk); chk_out("t3_h1", 16'h1004, 16'h0005, 1'b1); chk_req("t3_skid1", 1'b0, 16'h0);
      stall = 1'b0;
      @(negedge clk); chk_out("t3_w5", 16'h1005, 16'h0006, 1'b1); chk_req("t3_r6", 1'b1, 16'h0006);

      // 4: redirect to 0x40 while waiting on addr 7
      @(negedge clk); chk_out("t4_w6", 16'h1006, 16'h0007, 1'b1); chk_req("t4_r7", 1'b1, 16'h0007);
      imem_rdy = 1'b0;
      @(negedge clk); chk_out("t4_wait", 16'hF000, 16'h0007, 1'b0);
      redirect = 1'b1; target = 16'h0040;
      @(negedge clk); chk_out("t4_drain0", 16'hF000, 16'h0007, 1'b0); chk_req("t4_drain0", 1'b1, 16'h0007);
      redirect = 1'b0;
      @(negedge clk); chk_out("t4_drain1", 16'hF000, 16'h0007, 1'b0); chk_req("t4_drain1", 1'b1, 16'h0007);
      imem_rdy = 1'b1;
      @(negedge clk); chk_out("t4_discard", 16'hF000, 16'h0007, 1'b0); chk_req("t4_tgt", 1'b1, 16'h0040);
      @(negedge clk); chk_out("t4_w40", 16'h1040, 16'h0041, 1'b1);

      // 5: redirect beats stall, then fetch at 0xFFFF wraps PC_inc
      redirect = 1'b1; stall = 1'b1; target = 16'hFFFF;
      @(negedge clk); chk_out("t5_bub", 16'hF000, 16'h0041, 1'b0); chk_req("t5_tgt", 1'b1, 16'hFFFF);
      redirect = 1'b0; stall = 1'b0;
      @(negedge clk); chk_out("t5_wrap", 16'h0FFF, 16'h0000, 1'b1); chk_req("t5_r0", 1'b1, 16'h0000);

      // 6: halt while waiting, then reset restarts at RESET_PC
      imem_rdy = 1'b0;
      @(negedge clk); chk_out("t6_wait", 16'hF000, 16'h0000, 1'b0);
      halt = 1'b1;
      @(negedge clk);
      chk("t6_halted", {15'd0, halted}, 16'h1);
      chk_req("t6_h0", 1'b0, 16'h0);
      halt = 1'b0; imem_rdy = 1'b1;
      @(negedge clk);
      chk("t6_halted1", {15'd0, halted}, 16'h1);
      chk_out("t6_h1", 16'hF000, 16'h0000, 1'b0);
      redirect = 1'b1; target = 16'h0080;
      @(negedge clk);
      chk("t6_halted2", {15'd0, halted}, 16'h1);
      chk_req("t6_h2", 1'b0, 16'h0);
      redirect = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_halted", {15'd0, halted}, 16'h0);
      chk_req("t6_rst", 1'b0, 16'h0);
      chk_out("t6_rst", 16'hF000, 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); chk_req("t6_restart", 1'b1, 16'h0000);
      @(negedge clk); chk_out("t6_w0", 16'h1000, 16'h0001, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
